// File: rtl/adc_spi_capture.sv
// adc_spi_capture
// Serial front end for the external SPI ADC. A free-running period counter
// starts a conversion every SAMPLE_PERIOD clocks. convst is held for
// CONV_CYCLES clocks, then DATA_BITS bits are clocked out of the ADC's SDO
// pin MSB first. The result is presented as a held parallel word.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   enable     run sampling when high; low aborts CONV/SHIFT and clears overrun
//   sdo        ADC serial data out (source-synchronous to our sclk, no synchronizer)
//   convst     ADC conversion start, active high
//   cs_n       ADC chip select, active low
//   sclk       serial clock to the ADC
//   data_out   last complete sample, held until the next one
//   data_valid one-cycle pulse when data_out updates
//   busy       high while the FSM is not IDLE
//   overrun    sticky; a period tick arrived while a sample was in flight
//
// Handshake: data_valid is a single-cycle strobe with no back-pressure; the
// consumer must take data_out in that cycle or read the held value later.
module adc_spi_capture #(
    parameter int DATA_BITS     = 16,
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 200,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 sdo,
    output logic                 convst,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [PER_W-1:0]     period_cnt;
    logic [CONV_W-1:0]    conv_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick;

    assign tick = (period_cnt == PER_LAST) && enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            period_cnt <= '0;
            conv_cnt   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            convst     <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // Period counter only runs while enabled, so the first tick is
            // SAMPLE_PERIOD-1 cycles after enable rises.
            if (!enable || period_cnt == PER_LAST) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (!enable) begin
                overrun <= 1'b0;
            end else if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= CONV;
                        convst   <= 1'b1;
                        busy     <= 1'b1;
                        conv_cnt <= '0;
                    end
                end
                CONV: begin
                    if (!enable) begin
                        state  <= IDLE;
                        convst <= 1'b0;
                        busy   <= 1'b0;
                    end else if (conv_cnt == CONV_LAST) begin
                        state   <= SHIFT;
                        convst  <= 1'b0;
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!enable) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        sclk  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            // Rising sclk: the ADC has held sdo stable since
                            // the previous falling edge, so capture it now.
                            sclk      <= 1'b1;
                            shift_reg <= {shift_reg[DATA_BITS-2:0], sdo};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                cs_n  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Completes even if enable has just dropped.
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Testbench for adc_spi_capture. Three instances: a (CLK_DIV=2, period 100),
// b (period 50, forces overrun) and c (CLK_DIV=1). Each has an ADC model
// that shifts a chosen word MSB first, changing sdo after sclk falls.
module tb_adc_spi_capture;

    localparam int W = 16;
    localparam int B_CONVST = 5, B_CSN = 4, B_SCLK = 3, B_DV = 2, B_BUSY = 1, B_OVR = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable_a = 1'b0, enable_b = 1'b0, enable_c = 1'b0;
    logic sdo_a, sdo_b, sdo_c;
    logic convst_a, cs_n_a, sclk_a, dv_a, busy_a, ovr_a;
    logic convst_b, cs_n_b, sclk_b, dv_b, busy_b, ovr_b;
    logic convst_c, cs_n_c, sclk_c, dv_c, busy_c, ovr_c;
    logic [W-1:0] data_out_a, data_out_b, data_out_c;

    int assert_cnt = 0;
    int fail_cnt = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] exp_c[$];

    always #5 clk = ~clk;

    adc_spi_capture #(.DATA_BITS(W), .CLK_DIV(2), .CONV_CYCLES(5), .SAMPLE_PERIOD(100)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .sdo(sdo_a),
        .convst(convst_a), .cs_n(cs_n_a), .sclk(sclk_a), .data_out(data_out_a),
        .data_valid(dv_a), .busy(busy_a), .overrun(ovr_a));

    adc_spi_capture #(.DATA_BITS(W), .CLK_DIV(2), .CONV_CYCLES(5), .SAMPLE_PERIOD(50)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .sdo(sdo_b),
        .convst(convst_b), .cs_n(cs_n_b), .sclk(sclk_b), .data_out(data_out_b),
        .data_valid(dv_b), .busy(busy_b), .overrun(ovr_b));

    adc_spi_capture #(.DATA_BITS(W), .CLK_DIV(1), .CONV_CYCLES(5), .SAMPLE_PERIOD(100)) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(enable_c), .sdo(sdo_c),
        .convst(convst_c), .cs_n(cs_n_c), .sclk(sclk_c), .data_out(data_out_c),
        .data_valid(dv_c), .busy(busy_c), .overrun(ovr_c));

    // ---------------- ADC models ----------------
    logic [W-1:0] adc_word_a, adc_word_b, adc_word_c;
    logic [W-1:0] cur_a = '0, cur_b = '0, cur_c = '0;
    int idx_a = W - 1, idx_b = W - 1, idx_c = W - 1;

    always @(negedge cs_n_a) begin cur_a = adc_word_a; idx_a = W - 1; exp_a.push_back(adc_word_a); end
    always @(negedge cs_n_b) begin cur_b = adc_word_b; idx_b = W - 1; exp_b.push_back(adc_word_b); end
    always @(negedge cs_n_c) begin cur_c = adc_word_c; idx_c = W - 1; exp_c.push_back(adc_word_c); end
    always @(negedge sclk_a) if (idx_a > 0) idx_a = idx_a - 1;
    always @(negedge sclk_b) if (idx_b > 0) idx_b = idx_b - 1;
    always @(negedge sclk_c) if (idx_c > 0) idx_c = idx_c - 1;
    assign sdo_a = cur_a[idx_a];
    assign sdo_b = cur_b[idx_b];
    assign sdo_c = cur_c[idx_c];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every data_valid pops the word the model shifted out.
    always @(negedge clk) begin
        if (reset_n && dv_a) begin
            if (exp_a.size() == 0) check("a_dv_unexpected", 1, 0);
            else check("a_data", {16'h0, data_out_a}, {16'h0, exp_a.pop_front()});
        end
        if (reset_n && dv_b) begin
            if (exp_b.size() == 0) check("b_dv_unexpected", 1, 0);
            else check("b_data", {16'h0, data_out_b}, {16'h0, exp_b.pop_front()});
        end
        if (reset_n && dv_c) begin
            if (exp_c.size() == 0) check("c_dv_unexpected", 1, 0);
            else check("c_data", {16'h0, data_out_c}, {16'h0, exp_c.pop_front()});
        end
    end

    function automatic logic [5:0] sig(input int sel);
        case (sel)
            0:       sig = {convst_a, cs_n_a, sclk_a, dv_a, busy_a, ovr_a};
            1:       sig = {convst_b, cs_n_b, sclk_b, dv_b, busy_b, ovr_b};
            default: sig = {convst_c, cs_n_c, sclk_c, dv_c, busy_c, ovr_c};
        endcase
    endfunction

    // Counts negedges until signal bit_i of instance sel equals val.
    task automatic wait_for(input int sel, input int bit_i, input logic val, input int limit,
                            output int n);
        logic [5:0] s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = sig(sel);
        end while (s[bit_i] !== val && n < limit);
    endtask

    // Starting at the negedge where convst was first seen high, profiles one
    // sample up to its data_valid.
    task automatic measure(input int sel, output int convst_hi, output int cs_low,
                           output int rises, output int same, output int dv_at);
        logic [5:0] s;
        logic prev_sclk, prev_cs_n;
        convst_hi = 0; cs_low = 0; rises = 0; same = 0; dv_at = -1;
        prev_sclk = 1'b0; prev_cs_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            s = sig(sel);
            if (s[B_CONVST]) convst_hi++;
            if (!s[B_CSN]) cs_low++;
            if (s[B_SCLK] && !prev_sclk) rises++;
            if (!s[B_CSN] && !prev_cs_n && s[B_SCLK] == prev_sclk) same++;
            prev_sclk = s[B_SCLK];
            prev_cs_n = s[B_CSN];
            if (s[B_DV]) begin
                dv_at = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, ch, cl, ri, sm, dv_at, bad;
        logic [5:0] s;

        adc_word_a = 16'h0000;
        adc_word_b = 16'h0000;
        adc_word_c = 16'h0000;
        repeat (3) @(negedge clk);
        s = sig(0);
        check("reset_ctrl", {26'h0, s}, {26'h0, 6'b010000});
        check("reset_data", {16'h0, data_out_a}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: single 0xA5C3 sample
        adc_word_a = 16'hA5C3;
        enable_a = 1'b1;
        wait_for(0, B_CONVST, 1'b1, 300, n);
        check("t1_convst_start", n, 100);
        measure(0, ch, cl, ri, sm, dv_at);
        check("t1_convst_len", ch, 5);
        check("t1_cs_low", cl, 64);
        check("t1_sclk_pulses", ri, 16);
        check("t1_dv_latency", dv_at, 70);
        @(negedge clk);
        check("t1_dv_width", {31'h0, dv_a}, 0);

        // Test 2: back-to-back 0x0001 then 0xFFFF
        adc_word_a = 16'h0001;
        wait_for(0, B_DV, 1'b1, 300, n);
        check("t2_dv_spacing1", n, 99);
        adc_word_a = 16'hFFFF;
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!dv_a && data_out_a !== 16'h0001) bad++;
        end while (!dv_a && n < 300);
        check("t2_dv_spacing2", n, 100);
        check("t2_hold", bad, 0);
        check("t2_overrun", {31'h0, ovr_a}, 0);

        // Test 4: abort during bit 8 of SHIFT
        adc_word_a = 16'h1234;
        wait_for(0, B_CSN, 1'b0, 300, n);
        repeat (33) @(negedge clk);
        enable_a = 1'b0;
        @(negedge clk);
        check("t4_abort_pins", {28'h0, cs_n_a, sclk_a, busy_a, convst_a}, {28'h0, 4'b1000});
        if (exp_a.size() > 0) void'(exp_a.pop_back());
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (dv_a || busy_a) bad++;
        end
        check("t4_no_dv", bad, 0);
        check("t4_data_kept", {16'h0, data_out_a}, {16'h0, 16'hFFFF});

        // Test 5: reset pulse during CONV
        adc_word_a = 16'h5A5A;
        enable_a = 1'b1;
        wait_for(0, B_CONVST, 1'b1, 300, n);
        check("t5_convst_start", n, 100);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_async_reset", {15'h0, convst_a, cs_n_a, data_out_a}, {15'h0, 1'b0, 1'b1, 16'h0});
        @(negedge clk);
        reset_n = 1'b1;
        wait_for(0, B_CONVST, 1'b1, 300, n);
        check("t5_restart", n, 100);
        measure(0, ch, cl, ri, sm, dv_at);
        check("t5_dv_latency", dv_at, 70);
        enable_a = 1'b0;

        // Test 3: SAMPLE_PERIOD=50 forces overrun
        adc_word_b = 16'h0F0F;
        enable_b = 1'b1;
        wait_for(1, B_OVR, 1'b1, 300, n);
        check("t3_overrun_set", n, 100);
        wait_for(1, B_DV, 1'b1, 300, n);
        check("t3_first_dv", n, 20);
        adc_word_b = 16'h3C3C;
        wait_for(1, B_DV, 1'b1, 300, n);
        check("t3_dv_spacing", n, 100);
        check("t3_overrun_sticky", {31'h0, ovr_b}, 1);
        enable_b = 1'b0;
        @(negedge clk);
        check("t3_overrun_clear", {31'h0, ovr_b}, 0);

        // Test 6: CLK_DIV=1, MSB alignment
        adc_word_c = 16'h8000;
        enable_c = 1'b1;
        wait_for(2, B_CONVST, 1'b1, 300, n);
        check("t6_convst_start", n, 100);
        measure(2, ch, cl, ri, sm, dv_at);
        check("t6_cs_low", cl, 32);
        check("t6_sclk_pulses", ri, 16);
        check("t6_sclk_toggle", sm, 0);
        check("t6_dv_latency", dv_at, 38);
        enable_c = 1'b0;
        repeat (3) @(negedge clk);

        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        check("c_queue_empty", exp_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
